// File: rtl/mem_arbiter.sv
// Two-port arbitrated single-access memory: round-robin on ties, fixed LATENCY
// from accept to a one-cycle ready pulse, with out-of-range detection.
module mem_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ready0,
    output logic              ready1,
    output logic              err0,
    output logic              err1
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      BUSY_LAST = 4'(LATENCY - 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              last_grant;
    logic              lat_port;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              any_req;
    logic              grant;
    logic              op_port;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              in_range;
    logic              enter_done;
    logic [IDX_W-1:0]  idx;

    // With LATENCY=1 the accept edge is also the DONE-entry edge, so the
    // operation is taken straight from the granted port instead of the latch.
    always_comb begin
        any_req = req0 | req1;
        grant   = (req0 && req1) ? ~last_grant : req1;
        if (state == IDLE) begin
            op_port  = grant;
            op_we    = grant ? we1    : we0;
            op_addr  = grant ? addr1  : addr0;
            op_wdata = grant ? wdata1 : wdata0;
        end else begin
            op_port  = lat_port;
            op_we    = lat_we;
            op_addr  = lat_addr;
            op_wdata = lat_wdata;
        end
        in_range   = {1'b0, op_addr} < DEPTH_L;
        idx        = op_addr[IDX_W-1:0];
        enter_done = (state == IDLE && any_req && LATENCY == 1) ||
                     (state == BUSY && cnt == BUSY_LAST);
    end

    // Array has no reset; the rst_n gate keeps an aborted access from committing.
    always_ff @(posedge clk) begin
        if (rst_n && enter_done && op_we && in_range)
            mem[idx] <= op_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            lat_port   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            ready0     <= 1'b0;
            ready1     <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            ready0 <= 1'b0;
            ready1 <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    lat_port   <= grant;
                    lat_we     <= op_we;
                    lat_addr   <= op_addr;
                    lat_wdata  <= op_wdata;
                    last_grant <= grant;
                    cnt        <= '0;
                    state      <= (LATENCY == 1) ? DONE : BUSY;
                end
                BUSY: begin
                    if (cnt == BUSY_LAST) state <= DONE;
                    else                  cnt   <= cnt + 4'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_done) begin
                if (op_port) begin
                    ready1 <= 1'b1;
                    err1   <= ~in_range;
                    if (!op_we) rdata1 <= in_range ? mem[idx] : '0;
                end else begin
                    ready0 <= 1'b1;
                    err0   <= ~in_range;
                    if (!op_we) rdata0 <= in_range ? mem[idx] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: LATENCY=2 and LATENCY=1 instances driven from a
// transaction-level model; a monitor scores every ready pulse and rdata value.
module tb_mem_arbiter;

    localparam int DEPTH = 128;

    typedef struct packed {
        logic       en;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } op_t;

    typedef struct packed {
        int         dut;
        int         port;
        int         cyc;
        logic       rd;
        logic       er;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req   [2][2];
    logic       we    [2][2];
    logic [7:0] addr  [2][2];
    logic [7:0] wdata [2][2];
    logic [7:0] rdata [2][2];
    logic       ready [2][2];
    logic       err   [2][2];

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         idle_at [2];
    logic       mdl_last [2];
    logic [7:0] mdl_mem [2][256];
    logic [7:0] exp_rd [2][2];
    exp_t       expq [$];
    exp_t       mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0][0]), .req1(req[0][1]), .we0(we[0][0]), .we1(we[0][1]),
        .addr0(addr[0][0]), .addr1(addr[0][1]), .wdata0(wdata[0][0]), .wdata1(wdata[0][1]),
        .rdata0(rdata[0][0]), .rdata1(rdata[0][1]), .ready0(ready[0][0]), .ready1(ready[0][1]),
        .err0(err[0][0]), .err1(err[0][1])
    );

    mem_arbiter #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req[1][0]), .req1(req[1][1]), .we0(we[1][0]), .we1(we[1][1]),
        .addr0(addr[1][0]), .addr1(addr[1][1]), .wdata0(wdata[1][0]), .wdata1(wdata[1][1]),
        .rdata0(rdata[1][0]), .rdata1(rdata[1][1]), .ready0(ready[1][0]), .ready1(ready[1][1]),
        .err0(err[1][0]), .err1(err[1][1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic op_t mk(input logic en, input logic w, input logic [7:0] a, input logic [7:0] dt);
        op_t o;
        o.en = en; o.we = w; o.addr = a; o.data = dt;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.en   = 1'($urandom_range(0, 1));
        o.we   = 1'($urandom_range(0, 1));
        o.addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
        o.data = 8'($urandom);
        return o;
    endfunction

    task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, expv);
        end
    endtask

    task automatic drive(input int d, input int p, input op_t o);
        req[d][p]   = o.en;
        we[d][p]    = o.we;
        addr[d][p]  = o.addr;
        wdata[d][p] = o.data;
    endtask

    // Completion prediction: effects are applied in grant order.
    task automatic predict(input int d, input int p, input op_t o, input int rc);
        exp_t e;
        e.dut = d; e.port = p; e.cyc = rc;
        e.rd = ~o.we; e.er = (o.addr >= DEPTH); e.data = 8'h00;
        if (o.we) begin
            if (!e.er) mdl_mem[d][o.addr] = o.data;
        end else if (!e.er) begin
            e.data = mdl_mem[d][o.addr];
        end
        expq.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mdl_last[d] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0;
                exp_rd[d][p] = 8'h00;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                chk("reset_ready", d, 8'(ready[d][p]), 8'h00);
                chk("reset_err",   d, 8'(err[d][p]),   8'h00);
                chk("reset_rdata", d, rdata[d][p],     8'h00);
            end
        @(negedge clk);
        rst_n = 1'b1;
        idle_at[0] = cyc;
        idle_at[1] = cyc;
    endtask

    // Drive one round (one or two simultaneous requests); each requester holds
    // req until its predicted ready cycle, and the winner's operands are
    // scrambled right after accept to show they are latched.
    task automatic issue(input int d, input op_t o0, input op_t o1);
        int   L, t, n;
        int   rc [2];
        int   pp [2];
        op_t  oo [2];
        if (!o0.en && !o1.en) return;
        L = lat(d);
        while (cyc < idle_at[d]) @(negedge clk);
        t = cyc;
        oo[0] = o0; oo[1] = o1;
        if (o0.en && o1.en) begin
            pp[0] = mdl_last[d] ? 0 : 1;
            pp[1] = 1 - pp[0];
            n = 2;
        end else begin
            pp[0] = o0.en ? 0 : 1;
            pp[1] = 0;
            n = 1;
        end
        for (int k = 0; k < n; k++) begin
            rc[k] = t + k * (L + 1) + L;
            predict(d, pp[k], oo[pp[k]], rc[k]);
            mdl_last[d] = (pp[k] == 1);
        end
        drive(d, 0, o0);
        drive(d, 1, o1);
        @(negedge clk);
        drive(d, pp[0], mk(1'b1, 1'($urandom), 8'($urandom), 8'($urandom)));
        while (cyc < rc[0]) @(negedge clk);
        req[d][pp[0]] = 1'b0;
        if (n == 2) begin
            while (cyc < rc[1]) @(negedge clk);
            req[d][pp[1]] = 1'b0;
        end
        idle_at[d] = rc[n-1] + 1;
    endtask

    // Monitor: scores ready pulses against the queue and rdata every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    if (ready[d][p] === 1'b1) begin
                        checks++;
                        if (expq.size() == 0 || expq[0].dut != d || expq[0].port != p) begin
                            errors++;
                            $display("FAIL unexpected_ready dut%0d port%0d at cycle %0d", d, p, cyc);
                        end else begin
                            mon_e = expq.pop_front();
                            if (mon_e.cyc != cyc) begin
                                errors++;
                                $display("FAIL ready_cycle dut%0d port%0d: got %0d expected %0d", d, p, cyc, mon_e.cyc);
                            end
                            chk("err_flag", d, 8'(err[d][p]), 8'(mon_e.er));
                            if (mon_e.rd) exp_rd[d][p] = mon_e.data;
                        end
                    end
                    chk(p == 0 ? "rdata0" : "rdata1", d, rdata[d][p], exp_rd[d][p]);
                end
            if (expq.size() > 0 && expq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_ready dut%0d port%0d: expected at cycle %0d, now %0d",
                         expq[0].dut, expq[0].port, expq[0].cyc, cyc);
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                drive(d, p, mk(1'b0, 1'b0, 8'h00, 8'h00));
        do_reset();

        // Fill both arrays so every later read has a known value.
        for (int i = 0; i < 64; i++) begin
            issue(0, mk(1'b1, 1'b1, 8'(i), 8'($urandom)), mk(1'b1, 1'b1, 8'(i + 64), 8'($urandom)));
            issue(1, mk(1'b1, 1'b1, 8'(i), 8'($urandom)), mk(1'b1, 1'b1, 8'(i + 64), 8'($urandom)));
        end

        // Tie in the first cycle after reset, then a repeated tie.
        do_reset();
        issue(0, mk(1'b1, 1'b0, 8'd3, 8'h00), mk(1'b1, 1'b0, 8'd4, 8'h00));
        issue(0, mk(1'b1, 1'b0, 8'd10, 8'h00), mk(1'b1, 1'b0, 8'd11, 8'h00));

        // Write then read back on port 0.
        issue(0, mk(1'b1, 1'b1, 8'd5, 8'hA5), mk(1'b0, 1'b0, 8'h00, 8'h00));
        issue(0, mk(1'b1, 1'b0, 8'd5, 8'h00), mk(1'b0, 1'b0, 8'h00, 8'h00));

        // Out-of-range write/read; addr 72 aliases 200 in the low bits.
        issue(0, mk(1'b0, 1'b0, 8'h00, 8'h00), mk(1'b1, 1'b1, 8'd200, 8'hFF));
        issue(0, mk(1'b0, 1'b0, 8'h00, 8'h00), mk(1'b1, 1'b0, 8'd200, 8'h00));
        issue(0, mk(1'b1, 1'b0, 8'd72, 8'h00), mk(1'b0, 1'b0, 8'h00, 8'h00));

        // Reset during BUSY aborts the write to addr 7.
        while (cyc < idle_at[0]) @(negedge clk);
        drive(0, 0, mk(1'b1, 1'b1, 8'd7, 8'h3C));
        @(negedge clk);
        do_reset();
        issue(0, mk(1'b1, 1'b0, 8'd7, 8'h00), mk(1'b0, 1'b0, 8'h00, 8'h00));

        for (int i = 0; i < 200; i++) begin
            issue(0, rnd_op(), rnd_op());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // LATENCY=1 instance: single read, back-to-back ties, then random.
        issue(1, mk(1'b1, 1'b0, 8'd9, 8'h00), mk(1'b0, 1'b0, 8'h00, 8'h00));
        for (int i = 0; i < 4; i++)
            issue(1, mk(1'b1, 1'b1, 8'(20 + i), 8'($urandom)), mk(1'b1, 1'b0, 8'(20 + i), 8'h00));
        for (int i = 0; i < 100; i++) begin
            issue(1, rnd_op(), rnd_op());
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end

        for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d completions still outstanding, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
